cache_ctrl: RTL

- Direct-mapped write-back data-cache controller that sequences the 4-set cache storage array.
- Accepts word load/store requests from the core's MEM stage and performs hit lookup.
- On a miss it evicts a dirty victim, then refills the line from the memory interface.
- Sole driver of the array's enable, set-select and write-data inputs.

---
 rtl/cache_ctrl_pkg.sv | 28 ++
 rtl/cache_ctrl_if.sv | 35 +++
 rtl/cache_ctrl_line_merge.sv | 11 +
 rtl/cache_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/cache_ctrl_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
package cache_ctrl_pkg;
  localparam int ADDR_W          = 32;
  localparam int WORD_W          = 32;
  localparam int LINE_W          = 128;
  localparam int NUM_SETS        = 4;
  localparam int NUM_CACHE_LINES = NUM_SETS;
  localparam int CACHE_TAG_W     = 26;
  localparam int CACHE_IDX_W     = 2;
  localparam int CACHE_OFF_W     = 4;
  localparam int WOFF_W          = 2;

  typedef struct packed {
    logic                   valid;
    logic                   dirty;
    logic [CACHE_TAG_W-1:0] tag;
    logic [LINE_W-1:0]      data;
  } cache_set_t;

  typedef enum logic [2:0] {
    S_IDLE, S_WB_REQ, S_WB_WAIT, S_FILL_REQ, S_FILL_WAIT, S_RESPOND
  } cache_ctrl_state_e;

  function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                  input logic [WOFF_W-1:0] off);
    return line[off*WORD_W +: WORD_W];
  endfunction
endpackage

// File: rtl/cache_ctrl_if.sv
// Core request/response, cache array and memory-side signals of the cache controller.
interface cache_ctrl_if import cache_ctrl_pkg::*; ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              resp_valid;
  logic [WORD_W-1:0] resp_rdata;
  logic              cache_en;
  logic [1:0]        cache_set;
  cache_set_t        cache_wdata;
  cache_set_t        cache_rdata;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0] mem_req_wdata;
  logic              mem_resp_valid;
  logic [LINE_W-1:0] mem_resp_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, cache_rdata,
           mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output req_ready, resp_valid, resp_rdata, cache_en, cache_set, cache_wdata,
           mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, cache_rdata,
           mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  req_ready, resp_valid, resp_rdata, cache_en, cache_set, cache_wdata,
           mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata
  );
endinterface

// File: rtl/cache_ctrl_line_merge.sv
// Replaces one word of a cache line; shared by the store-hit and store-miss paths.
module cache_line_merge import cache_ctrl_pkg::*; (
  input  logic [LINE_W-1:0] line_in,
  input  logic [WOFF_W-1:0] off,
  input  logic [WORD_W-1:0] word,
  output logic [LINE_W-1:0] line_out
);
  for (genvar w = 0; w < LINE_W/WORD_W; w++) begin : g_word
    assign line_out[w*WORD_W +: WORD_W] = (off == WOFF_W'(w)) ? word : line_in[w*WORD_W +: WORD_W];
  end
endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped write-back cache controller: hit lookup, dirty eviction and line refill.
module cache_ctrl import cache_ctrl_pkg::*; (
  input  logic         clk,
  input  logic         reset,
  cache_ctrl_if.slave  bus
);
  cache_ctrl_state_e     state;
  logic                  lat_we;
  logic [ADDR_W-1:2]     lat_addr;
  logic [WORD_W-1:0]     lat_wdata;
  logic                  resp_valid_q;
  logic [WORD_W-1:0]     resp_rdata_q;
  logic                  mreq_valid_q, mreq_we_q;
  logic [ADDR_W-1:0]     mreq_addr_q;
  logic [LINE_W-1:0]     mreq_wdata_q;

  logic                   in_idle, hit, victim_dirty, wr_en;
  logic [CACHE_IDX_W-1:0] idx;
  logic [WOFF_W-1:0]      off;
  logic [CACHE_TAG_W-1:0] tag;
  logic [WORD_W-1:0]      st_word;
  logic [LINE_W-1:0]      merge_in, merged;
  cache_set_t             wr_line;
  logic                   unused_addr_lsb;

  assign unused_addr_lsb = ^bus.req_addr[1:0];
  assign in_idle = (state == S_IDLE);

  // In IDLE the lookup runs on the incoming request; afterwards on the latched one.
  always_comb begin
    idx      = in_idle ? bus.req_addr[5:4]  : lat_addr[5:4];
    off      = in_idle ? bus.req_addr[3:2]  : lat_addr[3:2];
    tag      = in_idle ? bus.req_addr[31:6] : lat_addr[31:6];
    st_word  = in_idle ? bus.req_wdata      : lat_wdata;
    merge_in = in_idle ? bus.cache_rdata.data : bus.mem_resp_rdata;
  end

  assign hit          = bus.cache_rdata.valid && (bus.cache_rdata.tag == bus.req_addr[31:6]);
  assign victim_dirty = bus.cache_rdata.valid && bus.cache_rdata.dirty;

  cache_line_merge u_merge (.line_in(merge_in), .off(off), .word(st_word), .line_out(merged));

  // The array writes whenever enabled, so the enable is decoded strictly per write cycle.
  always_comb begin
    wr_en   = 1'b0;
    wr_line = '0;
    if (reset) begin
      if (in_idle && bus.req_valid && bus.req_we && hit) begin
        wr_en   = 1'b1;
        wr_line = '{valid: 1'b1, dirty: 1'b1, tag: tag, data: merged};
      end else if (state == S_FILL_WAIT && bus.mem_resp_valid) begin
        wr_en   = 1'b1;
        wr_line = '{valid: 1'b1, dirty: lat_we, tag: tag,
                    data: lat_we ? merged : bus.mem_resp_rdata};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      mreq_valid_q <= 1'b0;
      mreq_we_q    <= 1'b0;
      mreq_addr_q  <= '0;
      mreq_wdata_q <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      case (state)
        S_IDLE: if (bus.req_valid) begin
          lat_we    <= bus.req_we;
          lat_addr  <= bus.req_addr[ADDR_W-1:2];
          lat_wdata <= bus.req_wdata;
          if (hit) begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= bus.req_we ? '0 : line_word(bus.cache_rdata.data, off);
          end else if (victim_dirty) begin
            mreq_valid_q <= 1'b1;
            mreq_we_q    <= 1'b1;
            mreq_addr_q  <= {bus.cache_rdata.tag, idx, 4'b0};
            mreq_wdata_q <= bus.cache_rdata.data;
            state        <= S_WB_REQ;
          end else begin
            mreq_valid_q <= 1'b1;
            mreq_we_q    <= 1'b0;
            mreq_addr_q  <= {tag, idx, 4'b0};
            mreq_wdata_q <= '0;
            state        <= S_FILL_REQ;
          end
        end
        S_WB_REQ: if (bus.mem_req_ready) begin
          mreq_valid_q <= 1'b0;
          state        <= S_WB_WAIT;
        end
        S_WB_WAIT: if (bus.mem_resp_valid) begin
          mreq_valid_q <= 1'b1;
          mreq_we_q    <= 1'b0;
          mreq_addr_q  <= {tag, idx, 4'b0};
          mreq_wdata_q <= '0;
          state        <= S_FILL_REQ;
        end
        S_FILL_REQ: if (bus.mem_req_ready) begin
          mreq_valid_q <= 1'b0;
          state        <= S_FILL_WAIT;
        end
        S_FILL_WAIT: if (bus.mem_resp_valid) begin
          resp_valid_q <= 1'b1;
          resp_rdata_q <= lat_we ? '0 : line_word(bus.mem_resp_rdata, off);
          state        <= S_RESPOND;
        end
        S_RESPOND: state <= S_IDLE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready     = in_idle;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_rdata    = resp_rdata_q;
  assign bus.cache_en      = wr_en;
  assign bus.cache_set     = idx;
  assign bus.cache_wdata   = wr_line;
  assign bus.mem_req_valid = mreq_valid_q;
  assign bus.mem_req_we    = mreq_we_q;
  assign bus.mem_req_addr  = mreq_addr_q;
  assign bus.mem_req_wdata = mreq_wdata_q;
endmodule
